// File: rtl/i2s_receiver.sv
// I2S receiver: synchronizes an external serial bus into clk and
// emits left/right word pairs with a one-cycle valid pulse.
// Ports: clk, rst (sync, active-high), s_clk, word_select, serial_in
// in; left_out, right_out, valid, frame_err out.
// Optional: define I2S_RX_FRAME_ERR_EN to enable the frame_err
// slot-length check; otherwise frame_err is tied to 0.
module i2s_receiver #(
  parameter int NUM_BITS  = 24,
  parameter int SLOT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_clk,
  input  logic                word_select,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] left_out,
  output logic [NUM_BITS-1:0] right_out,
  output logic                valid,
  output logic                frame_err
);

  localparam int CW = $clog2(SLOT_BITS + 2);
  localparam logic [CW-1:0] CNT_SAT  = CW'(SLOT_BITS + 1);
  localparam logic [CW-1:0] CNT_WORD = CW'(NUM_BITS);

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic [1:0] sck_sync;
  logic [1:0] ws_sync;
  logic [1:0] sd_sync;
  logic       sck_q;
  logic       rise;
  logic       ws_s;
  logic       sd_s;
  logic       ws_prev;
  logic       ws_seen;
  logic       ws_edge;

  logic                restart;
  logic                shift_en;
  logic                slot_end;
  logic [NUM_BITS-1:0] sr;
  logic [NUM_BITS-1:0] sr_nx;
  logic [NUM_BITS-1:0] word_nx;
  logic [NUM_BITS-1:0] stage;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nx;
  logic [CW-1:0]       pad;
  logic                left_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_q    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], s_clk};
      ws_sync  <= {ws_sync[0], word_select};
      sd_sync  <= {sd_sync[0], serial_in};
      sck_q    <= sck_sync[1];
    end
  end

  assign rise = sck_sync[1] & ~sck_q;
  assign ws_s = ws_sync[1];
  assign sd_s = sd_sync[1];

  // The first rise after reset only records WS; there is no
  // earlier level to compare it against yet.
  assign ws_edge = rise & ws_seen & (ws_s != ws_prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      ws_prev <= 1'b0;
      ws_seen <= 1'b0;
    end else if (rise) begin
      ws_prev <= ws_s;
      ws_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SYNC;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SYNC:    if (ws_edge) state_nx = ACTIVE;
      ACTIVE:  state_nx = ACTIVE;
      default: state_nx = SYNC;
    endcase
  end

  always_comb begin
    restart  = 1'b0;
    shift_en = 1'b0;
    slot_end = 1'b0;
    unique case (state)
      SYNC: begin
        restart = ws_edge;
      end
      ACTIVE: begin
        shift_en = rise & ~ws_edge;
        slot_end = ws_edge;
      end
      default: begin
        restart = 1'b0;
      end
    endcase
  end

  // The bit sampled on the WS-edge rise still belongs to the
  // ending slot, so the slot word includes it before justifying.
  always_comb begin
    cnt_nx = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
    sr_nx  = sr;
    if (cnt < CNT_WORD) begin
      sr_nx = {sr[NUM_BITS-2:0], sd_s};
    end
    pad = '0;
    if (cnt_nx < CNT_WORD) begin
      pad = CNT_WORD - cnt_nx;
    end
    word_nx = sr_nx << pad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      cnt       <= '0;
      stage     <= '0;
      left_done <= 1'b0;
      left_out  <= '0;
      right_out <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (restart) begin
        sr        <= '0;
        cnt       <= '0;
        left_done <= 1'b0;
      end else if (shift_en) begin
        sr  <= sr_nx;
        cnt <= cnt_nx;
      end else if (slot_end) begin
        sr  <= '0;
        cnt <= '0;
        if (!ws_prev) begin
          stage     <= word_nx;
          left_done <= 1'b1;
        end else if (left_done) begin
          left_out  <= stage;
          right_out <= word_nx;
          valid     <= 1'b1;
        end
      end
    end
  end

`ifdef I2S_RX_FRAME_ERR_EN
  localparam logic [CW-1:0] CNT_SLOT = CW'(SLOT_BITS);
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= slot_end & (cnt_nx != CNT_SLOT);
    end
  end

  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: drives I2S frames and
// checks output word pairs against a scoreboard queue.
module tb_i2s_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_clk;
  logic        word_select;
  logic        serial_in;
  logic [23:0] left_out;
  logic [23:0] right_out;
  logic        valid;
  logic        frame_err;

  int  compared   = 0;
  int  mismatched = 0;
  int  n_pulses   = 0;
  int  n_vcycles  = 0;
  int  n_err      = 0;
  bit  prev_valid = 1'b0;
  bit  jit        = 1'b0;

  logic [47:0] sb[$];

  i2s_receiver #(
    .NUM_BITS (24),
    .SLOT_BITS(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_clk      (s_clk),
    .word_select(word_select),
    .serial_in  (serial_in),
    .left_out   (left_out),
    .right_out  (right_out),
    .valid      (valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [47:0] exp;
    if (valid === 1'b1) begin
      n_vcycles++;
      if (!prev_valid) n_pulses++;
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_valid: got L=%h R=%h, want none",
                 left_out, right_out);
      end else begin
        exp = sb.pop_front();
        if ({left_out, right_out} !== exp) begin
          mismatched++;
          $display("FAIL word_pair: got L=%h R=%h, want L=%h R=%h",
                   left_out, right_out, exp[47:24], exp[23:0]);
        end
      end
    end
    if (frame_err === 1'b1) n_err++;
    prev_valid = (valid === 1'b1);
  end

  task automatic send_bits(input logic ws, input int n,
                           input logic [31:0] d, input bit tog,
                           input int ph);
    for (int i = 0; i < n; i++) begin
      if (jit) repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      s_clk       = 1'b0;
      word_select = (tog && i == n - 1) ? ~ws : ws;
      serial_in   = d[31-i];
      repeat (ph) @(negedge clk);
      s_clk = 1'b1;
      repeat (ph - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [23:0] l,
                            input logic [23:0] r, input int ph);
    send_bits(1'b0, 32, {l, 8'($urandom)}, 1'b1, ph);
    send_bits(1'b1, 32, {r, 8'($urandom)}, 1'b1, ph);
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: %0d pending, want 0", tag, sb.size());
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    s_clk       = 1'b0;
    word_select = 1'b0;
    serial_in   = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared += 4;
    if (left_out !== 24'h0) begin
      mismatched++;
      $display("FAIL reset_left: got %h, want 0", left_out);
    end
    if (right_out !== 24'h0) begin
      mismatched++;
      $display("FAIL reset_right: got %h, want 0", right_out);
    end
    if (valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_valid: got %b, want 0", valid);
    end
    if (frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ferr: got %b, want 0", frame_err);
    end
  endtask

  task automatic test_basic();
    int p0 = n_pulses;
    send_frame(24'hA5A5A5, 24'h5A5A5A, 8);
    sb.push_back({24'hA5A5A5, 24'h5A5A5A});
    send_frame(24'hA5A5A5, 24'h5A5A5A, 8);
    sb.push_back({24'hA5A5A5, 24'h5A5A5A});
    send_frame(24'hA5A5A5, 24'h5A5A5A, 8);
    wait_drain("basic");
    compared++;
    if (n_pulses - p0 != 2) begin
      mismatched++;
      $display("FAIL basic_pulses: got %0d, want 2", n_pulses - p0);
    end
  endtask

  task automatic test_back_to_back();
    int p0 = n_pulses;
    int c0 = n_vcycles;
    sb.push_back({24'h123456, 24'h654321});
    send_frame(24'h123456, 24'h654321, 4);
    sb.push_back({24'h000001, 24'h800000});
    send_frame(24'h000001, 24'h800000, 4);
    wait_drain("b2b");
    compared += 2;
    if (n_pulses - p0 != 2) begin
      mismatched++;
      $display("FAIL b2b_pulses: got %0d, want 2", n_pulses - p0);
    end
    if (n_vcycles - c0 != 2) begin
      mismatched++;
      $display("FAIL b2b_width: got %0d valid cycles, want 2",
               n_vcycles - c0);
    end
  endtask

  task automatic test_short_slot();
    int e0 = n_err;
    int want;
    sb.push_back({24'hABCD00, 24'h111111});
    send_bits(1'b0, 16, {16'hABCD, 16'h0}, 1'b1, 4);
    send_bits(1'b1, 32, {24'h111111, 8'hFF}, 1'b1, 4);
    wait_drain("short");
`ifdef I2S_RX_FRAME_ERR_EN
    want = 1;
`else
    want = 0;
`endif
    compared++;
    if (n_err - e0 != want) begin
      mismatched++;
      $display("FAIL short_ferr: got %0d pulses, want %0d",
               n_err - e0, want);
    end
  endtask

  task automatic test_mid_reset();
    int p0;
    send_bits(1'b0, 32, {24'h777777, 8'h00}, 1'b1, 4);
    send_bits(1'b1, 10, {24'h999999, 8'h00}, 1'b0, 4);
    compared += 2;
    if (left_out !== 24'hABCD00) begin
      mismatched++;
      $display("FAIL hold_left: got %h, want abcd00", left_out);
    end
    if (right_out !== 24'h111111) begin
      mismatched++;
      $display("FAIL hold_right: got %h, want 111111", right_out);
    end
    p0 = n_pulses;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compared += 2;
    if (left_out !== 24'h0) begin
      mismatched++;
      $display("FAIL midrst_left: got %h, want 0", left_out);
    end
    if (right_out !== 24'h0) begin
      mismatched++;
      $display("FAIL midrst_right: got %h, want 0", right_out);
    end
    send_bits(1'b1, 22, {10'h0, 22'h3FF0F0}, 1'b1, 4);
    compared++;
    if (n_pulses != p0) begin
      mismatched++;
      $display("FAIL midrst_early: got %0d pulses, want 0",
               n_pulses - p0);
    end
    sb.push_back({24'hC0FFEE, 24'h0BEEF1});
    send_frame(24'hC0FFEE, 24'h0BEEF1, 4);
    wait_drain("midrst");
  endtask

  task automatic test_jitter();
    logic [23:0] dl[3];
    logic [23:0] dr[3];
    for (int i = 0; i < 3; i++) begin
      dl[i] = 24'($urandom);
      dr[i] = 24'($urandom);
    end
    for (int i = 0; i < 3; i++) begin
      sb.push_back({dl[i], dr[i]});
      send_frame(dl[i], dr[i], 8);
    end
    wait_drain("ref8");
    jit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back({dl[i], dr[i]});
      send_frame(dl[i], dr[i], 3);
    end
    jit = 1'b0;
    wait_drain("jit3");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_short_slot();
    test_mid_reset();
    test_jitter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
